// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
package ps2_pkg;

  // Prefix byte that announces a key release.
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  // Prefix byte for extended keys; queued but ignored by key tracking.
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_LEN = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } dfr_state_t;

endpackage

// File: rtl/ps2_kbd_frontend_if.sv
// Pins, FIFO consumer handshake and seven-segment feeds of the keyboard front end.
interface ps2_kbd_frontend_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       pop;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;
  logic [3:0] code_hi;
  logic [3:0] code_lo;
  logic       code_valid;
  logic [3:0] cnt_hi;
  logic [3:0] cnt_lo;

  modport slave (
    input  ps2_clk, ps2_data, pop,
    output data, ready, overflow, frame_err,
           code_hi, code_lo, code_valid, cnt_hi, cnt_lo
  );

  modport master (
    output ps2_clk, ps2_data, pop,
    input  data, ready, overflow, frame_err,
           code_hi, code_lo, code_valid, cnt_hi, cnt_lo
  );
endinterface

// File: rtl/ps2_fifo.sv
// Small scan-code FIFO. A push while full is dropped and the contents are
// left untouched; a pop while empty is ignored. The head is presented
// directly from storage and reads as zero while empty.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset since empty gates the output.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_frontend.sv
// PS/2 keyboard front end: pin synchronizers, 11-bit frame deframer with
// abandon timer, scan-code FIFO and make/break key tracking that feeds the
// seven-segment nibble inputs.
//
//   state | meaning
//   IDLE  | waiting for a start bit (falling edge with data low)
//   SHIFT | collecting data, parity and stop bits; abandon timer running
//   CHECK | one cycle: validate parity/stop, push or flag an error
module ps2_kbd_frontend
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  ps2_kbd_frontend_if.slave  io_kbd
);

  localparam int SHIFT_W = PS2_FRAME_LEN - 1;
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_LEN - 1);

  logic [2:0]         r_clk_s;
  logic [2:0]         r_data_s;
  dfr_state_t         r_state;
  dfr_state_t         w_state_nxt;
  logic [3:0]         r_bitcnt;
  logic [SHIFT_W-1:0] r_shift;
  logic [TW-1:0]      r_tmr;
  logic               r_frame_err;
  logic               r_overflow;
  logic               r_brk_pend;
  logic [7:0]         r_code;
  logic               r_code_valid;
  logic [7:0]         r_press_cnt;

  logic       w_edge;
  logic       w_data_bit;
  logic       w_timeout;
  logic       w_frame_ok;
  logic       w_push;
  logic       w_err;
  logic [7:0] w_byte;
  logic [7:0] w_fifo_dout;
  logic       w_fifo_empty;
  logic       w_fifo_full;
  logic       w_unused;

  assign w_edge     = r_clk_s[2] & ~r_clk_s[1];
  assign w_data_bit = r_data_s[1];
  assign w_unused   = r_data_s[2];
  assign w_timeout  = (r_state == SHIFT) && (r_tmr == '0);
  assign w_byte     = r_shift[7:0];
  // Odd parity across data and parity bit, and a high stop bit.
  assign w_frame_ok = r_shift[SHIFT_W-1] && (^r_shift[8:0]);

  // Pin synchronizers, reset to the PS/2 idle level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_s  <= 3'b111;
      r_data_s <= 3'b111;
    end else begin
      r_clk_s  <= {r_clk_s[1:0],  io_kbd.ps2_clk};
      r_data_s <= {r_data_s[1:0], io_kbd.ps2_data};
    end
  end

  // Deframer state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Deframer next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_edge && !w_data_bit) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_edge && (r_bitcnt == LAST_BIT)) w_state_nxt = CHECK;
        else if (!w_edge && w_timeout)        w_state_nxt = IDLE;
      end
      CHECK:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Deframer outputs: accept a good frame, flag a bad start/parity/stop.
  always_comb begin
    w_push = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      IDLE:    w_err = w_edge && w_data_bit;
      CHECK: begin
        w_push = w_frame_ok;
        w_err  = !w_frame_ok;
      end
      default: begin
        w_push = 1'b0;
        w_err  = 1'b0;
      end
    endcase
  end

  // Bit counter, shift register and abandon down-timer (reloaded by each edge).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tmr    <= TMR_LOAD;
    end else begin
      if (w_edge || (r_state != SHIFT)) r_tmr <= TMR_LOAD;
      else if (r_tmr != '0)             r_tmr <= r_tmr - TW'(1);

      if ((r_state == IDLE) && w_edge) begin
        r_bitcnt <= 4'd1;
      end else if ((r_state == SHIFT) && w_edge) begin
        r_bitcnt <= r_bitcnt + 4'd1;
        r_shift  <= {w_data_bit, r_shift[SHIFT_W-1:1]};
      end
    end
  end

  // Registered error pulse and sticky overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_push && w_fifo_full) r_overflow <= 1'b1;
    end
  end

  // Make/break tracking on every accepted byte, independent of FIFO space.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_brk_pend   <= 1'b0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_press_cnt  <= '0;
    end else if (w_push) begin
      if (w_byte == PS2_BREAK) begin
        r_brk_pend <= 1'b1;
      end else if (w_byte == PS2_EXT) begin
        r_brk_pend <= r_brk_pend;
      end else if (r_brk_pend) begin
        r_brk_pend <= 1'b0;
        if (w_byte == r_code) r_code_valid <= 1'b0;
      end else if (!r_code_valid || (w_byte != r_code)) begin
        r_code       <= w_byte;
        r_code_valid <= 1'b1;
        r_press_cnt  <= r_press_cnt + 8'd1;
      end
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (w_byte),
    .i_pop   (io_kbd.pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign io_kbd.data       = w_fifo_dout;
  assign io_kbd.ready      = ~w_fifo_empty;
  assign io_kbd.overflow   = r_overflow;
  assign io_kbd.frame_err  = r_frame_err;
  assign io_kbd.code_hi    = r_code[7:4];
  assign io_kbd.code_lo    = r_code[3:0];
  assign io_kbd.code_valid = r_code_valid;
  assign io_kbd.cnt_hi     = r_press_cnt[7:4];
  assign io_kbd.cnt_lo     = r_press_cnt[3:0];

endmodule

// File: tb/tb_ps2_kbd_frontend.sv
// Scoreboard bench for the PS/2 keyboard front end: stimulus queues the
// expected bytes, a monitor pops the FIFO and compares, and a small key model
// supplies the expected tracking outputs.
`timescale 1ns/1ps
module tb_ps2_kbd_frontend;

  localparam int TMO  = 2000;
  localparam int HALF = 2;
  localparam int GAP  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_kbd_frontend_if kbd();

  ps2_kbd_frontend #(
    .FIFO_DEPTH  (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_kbd (kbd)
  );

  int         n_checks   = 0;
  int         n_pass     = 0;
  int         err_cycles = 0;
  logic [7:0] exp_q[$];
  bit         auto_pop   = 1'b0;

  logic [7:0] m_code;
  logic       m_valid;
  logic       m_brk;
  logic [7:0] m_cnt;

  logic [7:0] t2_seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      kbd.ps2_data = bits[i];
      tick(HALF);
      kbd.ps2_clk = 1'b0;
      tick(HALF);
      kbd.ps2_clk = 1'b1;
    end
    kbd.ps2_data = 1'b1;
    tick(GAP);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_brk = m_brk;
    else if (m_brk) begin
      m_brk = 1'b0;
      if (b == m_code) m_valid = 1'b0;
    end else if (!m_valid || (b != m_code)) begin
      m_code  = b;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 8'd1;
    end
  endtask

  task automatic check_track(input string name);
    check(name, int'({kbd.code_hi, kbd.code_lo, kbd.code_valid, kbd.cnt_hi, kbd.cnt_lo}),
          int'({m_code, m_valid, m_cnt}));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit enq);
    if (enq) exp_q.push_back(b);
    model_byte(b);
    send_bits(frame(b, 1'b0), 11);
    check_track("track");
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || kbd.ready) && n < 1000) begin
      tick(1);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    tick(1);
    check({name, "_ready_low"}, int'(kbd.ready), 0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_data"},       int'(kbd.data), 0);
    check({name, "_ready"},      int'(kbd.ready), 0);
    check({name, "_overflow"},   int'(kbd.overflow), 0);
    check({name, "_frame_err"},  int'(kbd.frame_err), 0);
    check({name, "_code"},       int'({kbd.code_hi, kbd.code_lo}), 0);
    check({name, "_code_valid"}, int'(kbd.code_valid), 0);
    check({name, "_cnt"},        int'({kbd.cnt_hi, kbd.cnt_lo}), 0);
  endtask

  // Monitor: pop whenever the FIFO presents a byte and compare with the scoreboard.
  initial begin
    logic [7:0] exp_b;
    kbd.pop = 1'b0;
    forever begin
      @(negedge clk);
      if (kbd.pop) begin
        kbd.pop = 1'b0;
      end else if (auto_pop && kbd.ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL fifo_unexpected: got 0x%0h expected no byte", kbd.data);
        end else begin
          exp_b = exp_q.pop_front();
          check("fifo_data", int'(kbd.data), int'(exp_b));
        end
        kbd.pop = 1'b1;
      end
    end
  end

  // Count cycles with frame_err high; a single pulse adds exactly one.
  initial begin
    forever begin
      @(negedge clk);
      if (kbd.frame_err === 1'b1) err_cycles++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    kbd.ps2_clk  = 1'b1;
    kbd.ps2_data = 1'b1;
    m_code = '0; m_valid = 1'b0; m_brk = 1'b0; m_cnt = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    check_reset("rst0");

    // Single make 0x1C.
    auto_pop = 1'b1;
    send_byte(8'h1C, 1'b1);
    check("t1_code_hi", int'(kbd.code_hi), 1);
    check("t1_code_lo", int'(kbd.code_lo), 12);
    check("t1_code_valid", int'(kbd.code_valid), 1);
    check("t1_cnt", int'({kbd.cnt_hi, kbd.cnt_lo}), 1);
    wait_drain("t1");

    // Typematic repeats then release; FIFO holds all five in order.
    auto_pop = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(t2_seq[i], 1'b1);
    check("t2_cnt", int'({kbd.cnt_hi, kbd.cnt_lo}), 1);
    check("t2_code_valid", int'(kbd.code_valid), 0);
    check("t2_ready", int'(kbd.ready), 1);
    auto_pop = 1'b1;
    wait_drain("t2");

    // Bad parity: one error pulse, nothing queued, tracking unchanged.
    e0 = err_cycles;
    send_bits(frame(8'h1C, 1'b1), 11);
    check("t3_err_pulse", err_cycles - e0, 1);
    check("t3_ready", int'(kbd.ready), 0);
    check_track("t3_track");

    // Overflow: nine frames into an eight-entry FIFO.
    check("t4_overflow_before", int'(kbd.overflow), 0);
    auto_pop = 1'b0;
    for (int i = 1; i <= 9; i++) send_byte(8'(i), i <= 8);
    check("t4_overflow", int'(kbd.overflow), 1);
    check("t4_ready", int'(kbd.ready), 1);
    auto_pop = 1'b1;
    wait_drain("t4");
    check("t4_overflow_sticky", int'(kbd.overflow), 1);

    // Partial frame abandoned by the timer, then a clean frame.
    e0 = err_cycles;
    send_bits(frame(8'h55, 1'b0), 5);
    tick(TMO + 5);
    send_byte(8'h32, 1'b1);
    wait_drain("t5");
    check("t5_no_err", err_cycles - e0, 0);

    // Reset in the middle of a frame.
    send_bits(frame(8'h77, 1'b0), 4);
    rst = 1'b1;
    tick(2);
    check_reset("rst_mid");
    rst = 1'b0;
    exp_q.delete();
    m_code = '0; m_valid = 1'b0; m_brk = 1'b0; m_cnt = '0;
    tick(2);
    check_reset("rst_after");
    send_byte(8'hE0, 1'b1);
    wait_drain("t6");

    // 256 alternating makes, each with its break: counter wraps to zero.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] k;
      k = (i % 2 == 0) ? 8'h1C : 8'h1B;
      send_byte(k, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(k, 1'b1);
    end
    check("t7_cnt_wrap", int'({kbd.cnt_hi, kbd.cnt_lo}), 0);
    check("t7_code_valid", int'(kbd.code_valid), 0);
    wait_drain("t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_frontend.md
# ps2_kbd_frontend

PS/2 keyboard front end for the NVBoard keyboard/seven-segment exercise. It samples the raw `ps2_clk`/`ps2_data` pins and deframes 11-bit PS/2 frames into a small scan-code FIFO. It also tracks make/break state and counts key presses. It drives the 4-bit nibble inputs of the downstream seven-segment decoders (last scan code, press count) together with blanking qualifiers.

## Interface
- `FIFO_DEPTH`, 8: scan-code FIFO entries; power of two, ≥2.
- `TIMEOUT_CYC`, 50000: `clk` cycles without a PS/2 falling edge before a partial frame is abandoned.
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw keyboard clock, asynchronous to `clk`.
- `ps2_data` in 1: raw keyboard data, asynchronous to `clk`.
- `pop` in 1: consumer dequeues the FIFO head; ignored when `ready`=0.
- `data` out 8: FIFO head byte; valid while `ready`=1.
- `ready` out 1: FIFO not empty.
- `overflow` out 1: sticky; set when a valid frame arrives with the FIFO full; cleared only by `rst`.
- `frame_err` out 1: one-cycle pulse on a start, stop or parity error.
- `code_hi`, `code_lo` out 4 each: nibbles of the last make code.
- `code_valid` out 1: a key is held; the decoders blank the code digits when it is 0.
- `cnt_hi`, `cnt_lo` out 4 each: nibbles of the 8-bit press counter.

## Operation
- Synchronizer: 3-flop chain on each pin. A falling edge is detected when `clk_s[2]`=1 and `clk_s[1]`=0. Data is sampled from `data_s[1]` in the same cycle.
- Deframer states:
  - IDLE: on an edge with sampled data=0 (start bit), go to SHIFT with bitcnt=1. An edge with data=1 stays in IDLE and pulses `frame_err`.
  - SHIFT: bits 1–8 are data, LSB first. Bit 9 is odd parity (data ^ parity must have an odd number of ones). Bit 10 is the stop bit (must be 1).
  - CHECK: taken on the bit-10 edge. If parity and stop are good, push to the FIFO. Otherwise pulse `frame_err` and discard. Return to IDLE.
- Timeout: a timer counts cycles since the last edge while in SHIFT. At `TIMEOUT_CYC` it returns to IDLE, discards the frame, and does not pulse `frame_err`.
- FIFO, push with full: the byte is dropped, `overflow` is set, and the contents are unchanged.
- FIFO, push and pop in the same cycle: both take effect. When the FIFO is non-full this gives net occupancy unchanged.
- FIFO, pop when empty: ignored.
- Key tracking on every accepted byte, in arrival order. The FIFO is not involved.
  - `0xF0` sets `brk_pend`. `0xE0` is passed to the FIFO only and has no tracking effect.
  - Another byte with `brk_pend`=1: clear `brk_pend`. If the byte equals the held code, `code_valid` goes to 0. `code_hi`/`code_lo` keep their value.
  - Another byte with `brk_pend`=0 is a make:
    - If `code_valid`=0, or the byte differs from the held code, latch it and set `code_valid`=1.
    - In that case also increment the press counter. It wraps 255→0.
    - A typematic repeat (same code while held) changes nothing.
- Reset values: all outputs 0 (`data`, `ready`, `overflow`, `frame_err`, nibbles, `code_valid`). Deframer in IDLE, FIFO empty, `brk_pend`=0, synchronizer flops at 1 (PS/2 idle level).
- Reset asserted mid-frame: the partial frame is lost. After release, the next start bit begins a fresh frame.

## Timing
- Pin-to-edge-detect latency: 3 `clk` cycles.
- `ready` rises 1 cycle after the CHECK cycle. `data` is valid in that same cycle.
- Tracking outputs update in the same cycle as `ready` for the byte concerned.
- `pop` is sampled on the rising edge of `clk`. The next head appears on `data` on the following cycle.
- `frame_err` is high for exactly one cycle, the cycle after CHECK.
- All outputs are registered; no combinational path from `ps2_*` or `pop` to an output.

## Structure
- Shared package `ps2_pkg` holds:
  - constants `PS2_BREAK=8'hF0` and `PS2_EXT=8'hE0`;
  - deframer state enum {IDLE, SHIFT, CHECK};
  - frame-length constant 11.
- One sub-module, `ps2_fifo` (parameterised by depth and width 8). Synchronizer, deframer and key tracker stay in the top level.

## Test plan
- Frame 0x1C (parity 0, stop 1) → `ready`=1, `data`=0x1C, `code_hi`=1, `code_lo`=C, `code_valid`=1, cnt=0x01.
- 0x1C, 0x1C, 0x1C (typematic), then 0xF0, 0x1C:
  - cnt stays 0x01; `code_valid`=0 after the last byte;
  - the FIFO holds 5 bytes in order; popping 5 times returns them and `ready` falls.
- Frame 0x1C with parity bit 1 → `frame_err` one-cycle pulse; FIFO empty; tracking unchanged.
- 9 valid frames 0x01..0x09 with no pop → `overflow`=1; pops return 0x01..0x08; 0x09 is lost.
- Partial frame (start + 4 bits), then idle for `TIMEOUT_CYC`+5 cycles, then full frame 0x32:
  - only 0x32 is queued; no `frame_err`.
- Other cases:
  - 256 distinct-alternating makes (0x1C/0x1B, each followed by its break) → cnt wraps to 0x00;
  - `rst` pulsed mid-frame → all outputs 0; the next full frame is received correctly.
